reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Generates board-level reset for the Nexys top from one external active-low reset plus a clock-manager lock indication.
- Produces NUM_CH independent active-high reset domains that are released in a fixed order, with a programmable initial hold time and a programmable gap between releases.
- Reasserts all domains on loss of lock or on a soft request, then runs the release sequence again.
- Sits directly under the top level, between the board reset pin and every functional block.

Parameters:
- NUM_CH, 4, number of sequenced reset outputs (≥1)
- SYNC_STAGES, 2, synchronizer depth for RST_N deassertion and locked_i (≥2)
- HOLD_CYCLES, 10, cycles all outputs stay asserted after sync before channel 0 releases (≥1)
- STAGE_GAP, 4, cycles between consecutive channel releases (≥1)

Ports:
- CLK  input  1  system clock, 100 MHz
- RST_N  input  1  asynchronous active-low reset, board pin
- locked_i  input  1  clock-manager lock, asynchronous to CLK
- soft_rst_req  input  1  synchronous pulse/level soft reset request (present only with RST_SEQ_SOFT_EN)
- rst_o  output  NUM_CH  per-domain active-high reset, registered
- rst_n_o  output  NUM_CH  bitwise inverse of rst_o, registered
- seq_done  output  1  high when all channels are released
- state_o  output  2  current FSM state encoding, for debug/LED

Behaviour:
- Interface: one clock, CLK. Reset is RST_N, asynchronous and active-low.
- RST_N low asynchronously forces all state:
  - rst_o = all 1, rst_n_o = all 0
  - seq_done = 0, state_o = RESET
  - both synchronizer chains cleared to 0
- Reset synchronizer: SYNC_STAGES flops shifting in 1; its output is rst_sync_n.
- Lock synchronizer: SYNC_STAGES flops on locked_i, also cleared by RST_N; its output is lock_s.
- FSM states and transitions:
  - RESET(0): go to HOLD when rst_sync_n && lock_s; counter loads HOLD_CYCLES-1.
  - HOLD(1): count down; at 0 go to RELEASE with idx=0, clear rst_o[0], load gap counter STAGE_GAP-1.
  - RELEASE(2): count down; at 0 increment idx and clear rst_o[idx]. After clearing rst_o[NUM_CH-1], go to RUN and set seq_done.
  - RUN(3): hold the released state.
- Required timing: let T0 be the first CLK edge where RST_N is sampled high, with locked_i already high.
  - rst_o[k] falls at edge T0 + SYNC_STAGES + HOLD_CYCLES + k*STAGE_GAP.
  - seq_done rises on the same edge as rst_o[NUM_CH-1] falls.
  - If lock arrives later, its first sampled-high edge T1 replaces T0.
- Released channels stay released. Unreleased channels stay asserted.
- lock_s falling in HOLD, RELEASE or RUN:
  - next edge sets all rst_o = 1 and seq_done = 0, state goes to RESET
  - counters are cleared
- RST_N low mid-sequence: immediate asynchronous return to the reset values. The sequence restarts from scratch with the full latency.
- Counter widths come from $clog2 of the maximum value, minimum 1 bit. No wrap; counters only count down from their loaded value.
- NUM_CH=1 is legal: RELEASE exits to RUN on the same edge channel 0 clears, and STAGE_GAP is unused.
- Outputs never glitch: all are flop outputs. rst_n_o is its own flop bank, not an inverter.

Optional Feature:
- Macro: RST_SEQ_SOFT_EN.
- Defined:
  - soft_rst_req port exists.
  - soft_rst_req high in HOLD, RELEASE or RUN acts exactly like a lock loss: next edge goes to RESET with all asserted.
  - In RESET, the FSM stays while soft_rst_req is high, then proceeds normally. Minimum reassert length is 1 + HOLD_CYCLES cycles.
  - If lock loss and soft request coincide, the result is identical, a single return to RESET.
- Undefined: the port is absent and soft reset logic is not generated.

Decomposition:
- Package rst_seq_pkg holds:
  - the typedef enum logic[1:0] {RESET, HOLD, RELEASE, RUN} seq_state_t
  - a function computing counter width max(1, $clog2(n))
- One sub-module, sync_bit: N-stage synchronizer with parameterised reset value. It is instantiated twice: reset chain shifting in 1, lock chain sampling locked_i.

Test Plan:
- Defaults, locked_i=1, RST_N released at T0 → rst_o[0..3] fall at T0+12/16/20/24; seq_done=1 at T0+24; rst_n_o is the mirror.
- locked_i=0 through reset release, raised at T1=T0+50 → rst_o[0] falls at T1+12; nothing falls earlier.
- In RELEASE after rst_o[1] falls, drop locked_i → all rst_o=1 by 3 edges later (2 sync + 1), state_o=0. Re-lock → full sequence restarts with +12 latency.
- RST_N pulsed low for 3 ns mid-RUN, not on a clock edge → rst_o=4'hF and seq_done=0 immediately (asynchronous). Sequence repeats after release.
- With RST_SEQ_SOFT_EN, 1-cycle soft_rst_req in RUN → all asserted next edge; rst_o[0] falls 11 edges later (HOLD only, no sync delay).
- Parameter sweep NUM_CH=1, STAGE_GAP=1, HOLD_CYCLES=1 → rst_o[0] falls at T0+3 and seq_done on the same edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and counter sizing for reset_sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage single-bit synchronizer with parameterised reset value
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-domain reset release with hold and gap timing
// Optional soft reset request input enabled by RST_SEQ_SOFT_EN.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              locked_i,
`ifdef RST_SEQ_SOFT_EN
  input  logic              soft_rst_req,
`endif
  output logic [NUM_CH-1:0] rst_o,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              seq_done,
  output logic [1:0]        state_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam int IW      = cnt_width(NUM_CH);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);

  logic rst_sync_n;
  logic lock_s;
  logic soft_w;

  seq_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     idx_nxt;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d_i   (1'b1),
    .q_o   (rst_sync_n)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d_i   (locked_i),
    .q_o   (lock_s)
  );

`ifdef RST_SEQ_SOFT_EN
  assign soft_w = soft_rst_req;
`else
  assign soft_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    idx_nxt = idx_q + 1'b1;

    case (state_q)
      RESET: begin
        rst_d  = '1;
        done_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (rst_sync_n && lock_s && !soft_w) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          rst_d[0] = 1'b0;
          idx_d    = '0;
          cnt_d    = GAP_LOAD;
          // A single domain finishes the whole sequence on its own release edge.
          if (NUM_CH == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          idx_d = idx_nxt;
          cnt_d = GAP_LOAD;
          for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(idx_nxt)) rst_d[i] = 1'b0;
          end
          if (idx_nxt == LAST_IDX) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RESET;
      end
    endcase

    // Lock loss or soft request anywhere past RESET restarts the whole sequence.
    if (state_q != RESET && (!lock_s || soft_w)) begin
      state_d = RESET;
      rst_d   = '1;
      done_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end

    rst_n_d = ~rst_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_o    = rst_q;
  assign rst_n_o  = rst_n_q;
  assign seq_done = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       locked_i;
  logic       soft_rst_req;
  logic [3:0] rst_o;
  logic [3:0] rst_n_o;
  logic       seq_done;
  logic [1:0] state_o;
  logic [0:0] r1_rst_o;
  logic [0:0] r1_rst_n_o;
  logic       r1_seq_done;
  logic [1:0] r1_state_o;

  int n_chk;
  int n_err;
  int cur_e;

  reset_sequencer dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .locked_i     (locked_i),
`ifdef RST_SEQ_SOFT_EN
    .soft_rst_req (soft_rst_req),
`endif
    .rst_o        (rst_o),
    .rst_n_o      (rst_n_o),
    .seq_done     (seq_done),
    .state_o      (state_o)
  );

  reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut1 (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .locked_i     (locked_i),
`ifdef RST_SEQ_SOFT_EN
    .soft_rst_req (soft_rst_req),
`endif
    .rst_o        (r1_rst_o),
    .rst_n_o      (r1_rst_n_o),
    .seq_done     (r1_seq_done),
    .state_o      (r1_state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_n;
    logic       lock;
    logic [3:0] rst;
    logic       done;
    logic [1:0] st;
    logic       r1;
    logic       d1;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic measure(input int lock_at, input string tag);
    int fall[4];
    int done_at;
    for (int k = 0; k < 4; k++) fall[k] = -1;
    done_at = -1;
    for (int e = 0; e <= lock_at + 40; e++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (fall[k] < 0 && rst_o[k] === 1'b0) fall[k] = e;
      end
      if (done_at < 0 && seq_done === 1'b1) done_at = e;
      if (lock_at > 0 && e == lock_at - 1) locked_i = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_fall%0d", tag, k), fall[k], lock_at + 12 + 4 * k);
    end
    chk($sformatf("%s_done", tag), done_at, lock_at + 24);
    chk($sformatf("%s_mirror", tag), {28'd0, rst_n_o}, {28'd0, ~rst_o});
  endtask

  initial begin
    int first0;
    n_chk = 0;
    n_err = 0;
    soft_rst_req = 1'b0;
    locked_i = 1'b1;
    RST_N = 1'b0;

    //           edge lock rst    done st    r1    d1
    tbl[0]  = '{0,  1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{2,  1'b1, 4'hF, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{3,  1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{11, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{12, 1'b1, 4'hE, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{15, 1'b1, 4'hE, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[7]  = '{16, 1'b1, 4'hC, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[8]  = '{19, 1'b1, 4'hC, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[9]  = '{20, 1'b1, 4'h8, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[10] = '{23, 1'b1, 4'h8, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[11] = '{24, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[12] = '{30, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 1'b1};

    #22;
    @(negedge CLK);
    chk("reset_rst_o", {28'd0, rst_o}, 32'hF);
    chk("reset_rst_n_o", {28'd0, rst_n_o}, 32'h0);
    chk("reset_done", {31'd0, seq_done}, 32'd0);
    chk("reset_state", {30'd0, state_o}, 32'd0);

    RST_N = 1'b1;
    cur_e = -1;
    for (int i = 0; i < 13; i++) begin
      locked_i = tbl[i].lock;
      while (cur_e < tbl[i].edge_n) begin
        tick();
        cur_e++;
      end
      chk($sformatf("tbl%0d_rst_o", tbl[i].edge_n), {28'd0, rst_o}, {28'd0, tbl[i].rst});
      chk($sformatf("tbl%0d_rst_n_o", tbl[i].edge_n), {28'd0, rst_n_o}, {28'd0, ~tbl[i].rst});
      chk($sformatf("tbl%0d_done", tbl[i].edge_n), {31'd0, seq_done}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_state", tbl[i].edge_n), {30'd0, state_o}, {30'd0, tbl[i].st});
      chk($sformatf("tbl%0d_ch1_rst", tbl[i].edge_n), {31'd0, r1_rst_o}, {31'd0, tbl[i].r1});
      chk($sformatf("tbl%0d_ch1_done", tbl[i].edge_n), {31'd0, r1_seq_done}, {31'd0, tbl[i].d1});
    end

    // Short asynchronous RST_N pulse between edges while in RUN.
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_o", {28'd0, rst_o}, 32'hF);
    chk("async_rst_n_o", {28'd0, rst_n_o}, 32'h0);
    chk("async_done", {31'd0, seq_done}, 32'd0);
    chk("async_state", {30'd0, state_o}, 32'd0);
    #2 RST_N = 1'b1;
    measure(0, "async_restart");

    // Lock loss in RELEASE right after channel 1 releases.
    RST_N = 1'b0;
    #12;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int e = 0; e <= 16; e++) tick();
    chk("lockloss_pre", {28'd0, rst_o}, 32'hC);
    locked_i = 1'b0;
    tick();
    tick();
    chk("lockloss_e2", {28'd0, rst_o}, 32'hC);
    tick();
    chk("lockloss_rst_o", {28'd0, rst_o}, 32'hF);
    chk("lockloss_state", {30'd0, state_o}, 32'd0);
    chk("lockloss_done", {31'd0, seq_done}, 32'd0);
    locked_i = 1'b1;
    measure(0, "relock");

    // Lock absent through reset release, arrives 50 edges later.
    RST_N = 1'b0;
    locked_i = 1'b0;
    #20;
    @(negedge CLK);
    RST_N = 1'b1;
    measure(50, "late_lock");

`ifdef RST_SEQ_SOFT_EN
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft_rst_o", {28'd0, rst_o}, 32'hF);
    chk("soft_state", {30'd0, state_o}, 32'd0);
    chk("soft_done", {31'd0, seq_done}, 32'd0);
    first0 = -1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (first0 < 0 && rst_o[0] === 1'b0) first0 = j;
    end
    chk("soft_fall0", first0, 11);
`else
    first0 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
